reverb_multitap: RTL and testbench
==================================

REVERB_MULTITAP -- requirements
Module: reverb_multitap

Interface
REQ-001 Parameter DW, 16, sample width in bits (signed two's complement).
REQ-002 Parameter AW, 17, delay-memory address width.
REQ-003 Parameter DEPTH, 90000, delay-memory words; 2 <= DEPTH <= 2^AW.
REQ-004 Parameter NTAPS, 8, number of read taps; 1..16.
REQ-005 Parameter TAP_DELAY, packed NTAPS*AW bits, tap i delay in samples at bits [i*AW +: AW]; each value 1..DEPTH-1.
REQ-006 Parameter TAP_SHIFT, packed NTAPS*4 bits, tap i attenuation as an arithmetic right shift at [i*4 +: 4].
REQ-007 Parameter FB_SHIFT, 4, attenuation shift applied to the previous wet sum before feedback.
REQ-008 clk_50m  in  1  system clock; all logic on its rising edge.
REQ-009 rst_n  in  1  reset; one clock, synchronous, active-low.
REQ-010 reverb_on  in  1  1 = reverb active, 0 = bypass.
REQ-011 ready_in  in  1  single-cycle strobe: signal_in valid.
REQ-012 signal_in  in  DW  dry input sample.
REQ-013 mix  in  5  wet proportion in 16ths; values above 16 are treated as 16; sampled with ready_in.
REQ-014 signal_out  out  DW  processed sample, registered.
REQ-015 ready_out  out  1  single-cycle strobe: signal_out updated.
REQ-016 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-017 Delay memory: single-port, DEPTH x DW, internal, 1-cycle registered read latency; one access per clock.
REQ-018 FSM states: IDLE, WRITE, READ, DRAIN, MIX, OUT.
- IDLE to WRITE on ready_in=1.
- WRITE to READ after 1 cycle.
- READ to DRAIN after NTAPS cycles.
- DRAIN to MIX, then MIX to OUT, then OUT to IDLE, each after 1 cycle.
REQ-019 On the IDLE edge that samples ready_in, the block latches signal_in as dry and latches the clamped mix.
REQ-020 WRITE: mem[wptr] = sat_DW(dry + (fb >>> FB_SHIFT)), where fb is the previous saturated wet sum.
REQ-021 READ cycle k (k = 0..NTAPS-1): the block issues address wrap(wptr - TAP_DELAY[k]).
- wrap adds DEPTH when the difference is negative; the result is always in 0..DEPTH-1.
REQ-022 Data for tap k is accumulated one cycle after its address is issued; the last tap's data is accumulated in DRAIN.
REQ-023 Each tap's contribution is (data >>> TAP_SHIFT[k]).
- A tap contributes 0 when TAP_DELAY[k] > fill, where fill = samples written since reset or bypass, saturating at DEPTH.
- This removes the need to clear the memory.
REQ-024 Accumulator width is DW + ceil(log2(NTAPS)) + 1, signed; it cannot overflow.
REQ-025 MIX: wet = sat_DW(acc); out = sat_DW((dry*(16-mix) + wet*mix) >>> 4); fb <= wet.
REQ-026 OUT: signal_out <= out; ready_out = 1 for exactly this one cycle.
- wptr advances to wptr+1, wrapping DEPTH-1 to 0.
- fill increments, saturating at DEPTH.
REQ-027 Latency: ready_out is high in the cycle NTAPS+4 clocks after the edge that sampled ready_in; maximum throughput is one sample per NTAPS+5 clocks.
REQ-028 ready_in asserted while busy=1 is ignored and the sample is dropped; no state changes.
REQ-029 sat_DW clamps to [-2^(DW-1), 2^(DW-1)-1].
REQ-030 Bypass (reverb_on=0), sampled each clock:
- FSM forced to IDLE; any in-flight sample is abandoned with no ready_out.
- wptr, fill and fb cleared; no memory writes.
- signal_out <= signal_in and ready_out <= 1 on the clock after each ready_in=1.
REQ-031 reverb_on rising: normal operation starts on the next clock with an empty history (fill=0).

Reset
REQ-032 rst_n=0 at a clock edge:
- FSM to IDLE.
- signal_out=0, ready_out=0, busy=0.
- wptr=0, fill=0, fb=0, accumulator=0.
- Reset takes priority over reverb_on and ready_in, and aborts any operation in progress without ready_out.
REQ-033 Memory contents are not reset; REQ-023 guarantees that unwritten locations are never heard.

Verification
REQ-034 Impulse response.
- Setup: DEPTH=16, NTAPS=2, TAP_DELAY={5,3}, TAP_SHIFT={2,1}, FB_SHIFT=15, mix=16.
- Stimulus: sample 0 = 16384, then zeros.
- Required: outputs 0,0,0,8192,0,4096,0,...
REQ-035 Dry path.
- Stimulus: mix=0; input 1000, -1000.
- Required: output 1000, -1000; ready_out exactly NTAPS+4 clocks after each ready_in.
REQ-036 Saturation.
- Setup: NTAPS=2, shifts {0,0}, delays {1,2}, mix=16.
- Stimulus: a constant 32767 stream.
- Required: from sample 2 onward the output is 32767; it never wraps negative.
REQ-037 Wrap-around.
- Setup: DEPTH=16, delay 15.
- Stimulus: 40 samples of a ramp.
- Required: output n equals input n-15 (scaled by the tap shift) across wptr wraps 15 to 0.
REQ-038 Handshake.
- Stimulus: ready_in pulsed again while busy.
- Required: that sample is dropped, only one ready_out is produced, and the next ready_in accepted in IDLE is processed normally.
REQ-039 Abort.
- Stimulus: rst_n=0 (or reverb_on=0) during READ.
- Required: no ready_out, busy=0 on the next clock, and after re-enable the taps output 0 until fill reaches each tap's delay.

Source files
------------

// File: rtl/reverb_multitap_if.sv
// Sample handshake bundle between a sample source and the multitap reverb.
// The master drives control and dry samples; the slave returns processed samples and status.
interface reverb_multitap_if #(
  parameter int unsigned DW = 16
);
  logic          reverb_on;
  logic          ready_in;
  logic [DW-1:0] signal_in;
  logic [4:0]    mix;
  logic [DW-1:0] signal_out;
  logic          ready_out;
  logic          busy;

  modport master (
    output reverb_on, ready_in, signal_in, mix,
    input  signal_out, ready_out, busy
  );

  modport slave (
    input  reverb_on, ready_in, signal_in, mix,
    output signal_out, ready_out, busy
  );
endinterface

// File: rtl/reverb_multitap.sv
// Multitap feedback reverb: one write and NTAPS reads of a single-port delay line per sample,
// followed by a wet/dry crossfade controlled by mix in 16ths.
module reverb_multitap #(
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 17,
  parameter int unsigned DEPTH     = 90000,
  parameter int unsigned NTAPS     = 8,
  parameter logic [NTAPS*AW-1:0] TAP_DELAY = {17'd80000, 17'd67000, 17'd53000, 17'd41000,
                                              17'd29000, 17'd17000, 17'd9000,  17'd2205},
  parameter logic [NTAPS*4-1:0]  TAP_SHIFT = {4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2, 4'd1},
  parameter int unsigned FB_SHIFT  = 4
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  reverb_multitap_if.slave bus
);

  localparam int unsigned TW   = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int unsigned ACCW = DW + $clog2(NTAPS) + 1;
  localparam int unsigned SW   = (ACCW > DW + 8) ? ACCW : DW + 8;

  localparam logic signed [SW-1:0] SMAX = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_MIX, S_OUT} state_e;

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v > SMAX)      return SMAX[DW-1:0];
    else if (v < SMIN) return SMIN[DW-1:0];
    else               return v[DW-1:0];
  endfunction

  state_e                   state_q, state_d;
  logic [TW-1:0]            tap_q, tap_d;
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [AW:0]              fill_q, fill_d;
  logic signed [DW-1:0]     fb_q, fb_d;
  logic signed [DW-1:0]     dry_q, dry_d;
  logic [4:0]               mix_q, mix_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic signed [DW-1:0]     out_q, out_d;
  logic                     rd_vld_q, rd_vld_d;
  logic                     rd_use_q, rd_use_d;
  logic [TW-1:0]            rd_tap_q, rd_tap_d;
  logic [DW-1:0]            signal_out_q, signal_out_d;
  logic                     ready_out_q, ready_out_d;
  logic                     busy_q, busy_d;

  logic [DW-1:0]            mem [DEPTH];
  logic [DW-1:0]            rdata_q;
  logic                     mem_we;
  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_wdata;

  logic [AW-1:0]            delay_a [NTAPS];
  logic [3:0]               shift_a [NTAPS];

  for (genvar i = 0; i < NTAPS; i++) begin : g_taps
    assign delay_a[i] = TAP_DELAY[i*AW +: AW];
    assign shift_a[i] = TAP_SHIFT[i*4 +: 4];
  end

  // Tap read address: wptr - delay, folded back into 0..DEPTH-1.
  logic [AW:0]   rd_diff;
  logic [AW:0]   rd_wrapped;
  logic [AW-1:0] rd_addr;
  assign rd_diff    = {1'b0, wptr_q} - {1'b0, delay_a[tap_q]};
  assign rd_wrapped = rd_diff + (AW+1)'(DEPTH);
  assign rd_addr    = rd_diff[AW] ? rd_wrapped[AW-1:0] : rd_diff[AW-1:0];

  logic signed [DW-1:0] rdata_s;
  logic signed [DW-1:0] contrib;
  logic signed [DW-1:0] wr_data;
  logic signed [DW-1:0] wet;
  logic signed [SW-1:0] mix_sum;
  logic signed [DW-1:0] mix_out;

  assign rdata_s = $signed(rdata_q);
  assign contrib = rd_use_q ? (rdata_s >>> shift_a[rd_tap_q]) : '0;
  assign wr_data = sat(SW'(dry_q) + SW'(fb_q >>> FB_SHIFT));
  assign wet     = sat(SW'(acc_q));
  assign mix_sum = SW'(dry_q) * SW'($signed({1'b0, 5'd16 - mix_q}))
                 + SW'(wet)   * SW'($signed({1'b0, mix_q}));
  assign mix_out = sat(mix_sum >>> 4);

  // Single-port delay memory with registered read; contents are never cleared.
  always_ff @(posedge clk_50m) begin
    if (mem_we && rst_n) mem[mem_addr] <= mem_wdata;
    rdata_q <= mem[mem_addr];
  end

  always_ff @(posedge clk_50m) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      wptr_q       <= '0;
      fill_q       <= '0;
      fb_q         <= '0;
      dry_q        <= '0;
      mix_q        <= '0;
      acc_q        <= '0;
      out_q        <= '0;
      rd_vld_q     <= 1'b0;
      rd_use_q     <= 1'b0;
      rd_tap_q     <= '0;
      signal_out_q <= '0;
      ready_out_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      wptr_q       <= wptr_d;
      fill_q       <= fill_d;
      fb_q         <= fb_d;
      dry_q        <= dry_d;
      mix_q        <= mix_d;
      acc_q        <= acc_d;
      out_q        <= out_d;
      rd_vld_q     <= rd_vld_d;
      rd_use_q     <= rd_use_d;
      rd_tap_q     <= rd_tap_d;
      signal_out_q <= signal_out_d;
      ready_out_q  <= ready_out_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    wptr_d       = wptr_q;
    fill_d       = fill_q;
    fb_d         = fb_q;
    dry_d        = dry_q;
    mix_d        = mix_q;
    acc_d        = acc_q;
    out_d        = out_q;
    rd_vld_d     = 1'b0;
    rd_use_d     = rd_use_q;
    rd_tap_d     = rd_tap_q;
    signal_out_d = signal_out_q;
    ready_out_d  = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = rd_addr;
    mem_wdata    = wr_data;

    // Read data lands one clock after its address, so accumulation trails issue by one.
    if (rd_vld_q) acc_d = acc_q + ACCW'(contrib);

    case (state_q)
      S_IDLE: begin
        if (bus.ready_in) begin
          dry_d   = $signed(bus.signal_in);
          mix_d   = (bus.mix > 5'd16) ? 5'd16 : bus.mix;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = wptr_q;
        acc_d    = '0;
        tap_d    = '0;
        state_d  = S_READ;
      end
      S_READ: begin
        rd_vld_d = 1'b1;
        rd_use_d = (AW+1)'(delay_a[tap_q]) <= fill_q;
        rd_tap_d = tap_q;
        if (tap_q == TW'(NTAPS - 1)) state_d = S_DRAIN;
        else                         tap_d   = tap_q + TW'(1);
      end
      S_DRAIN: state_d = S_MIX;
      S_MIX: begin
        fb_d    = wet;
        out_d   = mix_out;
        state_d = S_OUT;
      end
      S_OUT: begin
        signal_out_d = out_q;
        ready_out_d  = 1'b1;
        wptr_d       = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        fill_d       = (fill_q == (AW+1)'(DEPTH)) ? fill_q : fill_q + (AW+1)'(1);
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bypass discards history and in-flight work, passing samples straight through.
    if (!bus.reverb_on) begin
      state_d     = S_IDLE;
      wptr_d      = '0;
      fill_d      = '0;
      fb_d        = '0;
      acc_d       = '0;
      rd_vld_d    = 1'b0;
      mem_we      = 1'b0;
      ready_out_d = bus.ready_in;
      if (bus.ready_in) signal_out_d = bus.signal_in;
    end

    busy_d = (state_d != S_IDLE);
  end

  assign bus.signal_out = signal_out_q;
  assign bus.ready_out  = ready_out_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_reverb_multitap.sv
// Directed bench for reverb_multitap: three parameterisations share one stimulus stream.
module tb_reverb_multitap;
  logic        clk_50m = 1'b0;
  logic        rst_n;
  logic        reverb_on;
  logic        ready_in;
  logic [15:0] signal_in;
  logic [4:0]  mix;

  int n_tests = 0;
  int n_fail  = 0;

  int          cnt_imp, cnt_sat, cnt_wrap, lat_imp, lat_wrap;
  logic [15:0] val_imp, val_sat, val_wrap;

  always #10 clk_50m = ~clk_50m;

  reverb_multitap_if #(.DW(16)) imp_if ();
  reverb_multitap_if #(.DW(16)) sat_if ();
  reverb_multitap_if #(.DW(16)) wrap_if ();

  assign imp_if.reverb_on  = reverb_on;
  assign imp_if.ready_in   = ready_in;
  assign imp_if.signal_in  = signal_in;
  assign imp_if.mix        = mix;
  assign sat_if.reverb_on  = reverb_on;
  assign sat_if.ready_in   = ready_in;
  assign sat_if.signal_in  = signal_in;
  assign sat_if.mix        = mix;
  assign wrap_if.reverb_on = reverb_on;
  assign wrap_if.ready_in  = ready_in;
  assign wrap_if.signal_in = signal_in;
  assign wrap_if.mix       = mix;

  reverb_multitap #(
    .DW(16), .AW(4), .DEPTH(16), .NTAPS(2),
    .TAP_DELAY({4'd5, 4'd3}), .TAP_SHIFT({4'd2, 4'd1}), .FB_SHIFT(15)
  ) u_imp (.clk_50m(clk_50m), .rst_n(rst_n), .bus(imp_if));

  reverb_multitap #(
    .DW(16), .AW(5), .DEPTH(16), .NTAPS(2),
    .TAP_DELAY({5'd2, 5'd1}), .TAP_SHIFT({4'd0, 4'd0}), .FB_SHIFT(4)
  ) u_sat (.clk_50m(clk_50m), .rst_n(rst_n), .bus(sat_if));

  reverb_multitap #(
    .DW(16), .AW(4), .DEPTH(16), .NTAPS(1),
    .TAP_DELAY(4'd15), .TAP_SHIFT(4'd1), .FB_SHIFT(15)
  ) u_wrap (.clk_50m(clk_50m), .rst_n(rst_n), .bus(wrap_if));

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk_50m);
    rst_n = 1'b0;
    ready_in = 1'b0;
    @(negedge clk_50m);
    @(negedge clk_50m);
    rst_n = 1'b1;
  endtask

  // One-cycle ready_in pulse, then watch every DUT for 13 cycles.
  task automatic send(input logic [15:0] x);
    cnt_imp = 0; cnt_sat = 0; cnt_wrap = 0; lat_imp = -1; lat_wrap = -1;
    val_imp = 'x; val_sat = 'x; val_wrap = 'x;
    @(negedge clk_50m);
    signal_in = x;
    ready_in  = 1'b1;
    @(negedge clk_50m);
    ready_in  = 1'b0;
    for (int j = 0; j < 13; j++) begin
      if (imp_if.ready_out)  begin cnt_imp++;  val_imp  = imp_if.signal_out;  lat_imp  = j; end
      if (sat_if.ready_out)  begin cnt_sat++;  val_sat  = sat_if.signal_out;  end
      if (wrap_if.ready_out) begin cnt_wrap++; val_wrap = wrap_if.signal_out; lat_wrap = j; end
      @(negedge clk_50m);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (imp_if.signal_out !== 16'd0 || imp_if.ready_out !== 1'b0 || imp_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_imp: got out=%0d rdy=%b busy=%b, want 0 0 0",
               imp_if.signal_out, imp_if.ready_out, imp_if.busy);
    end
    n_tests++;
    if (wrap_if.signal_out !== 16'd0 || wrap_if.ready_out !== 1'b0 || wrap_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wrap: got out=%0d rdy=%b busy=%b, want 0 0 0",
               wrap_if.signal_out, wrap_if.ready_out, wrap_if.busy);
    end
  endtask

  task automatic test_impulse();
    int exp_v [8] = '{0, 0, 0, 8192, 0, 4096, 0, 0};
    do_reset();
    mix = 5'd16;
    for (int i = 0; i < 8; i++) begin
      send((i == 0) ? 16'd16384 : 16'd0);
      n_tests++;
      if (cnt_imp !== 1 || val_imp !== 16'(exp_v[i])) begin
        n_fail++;
        $display("FAIL impulse[%0d]: got %0d (pulses %0d), want %0d", i, $signed(val_imp), cnt_imp, exp_v[i]);
      end
    end
  endtask

  task automatic test_dry_path();
    int xs [2] = '{1000, -1000};
    mix = 5'd0;
    for (int i = 0; i < 2; i++) begin
      send(16'(xs[i]));
      n_tests++;
      if (cnt_imp !== 1 || val_imp !== 16'(xs[i]) || lat_imp !== 6) begin
        n_fail++;
        $display("FAIL dry_imp[%0d]: got %0d lat %0d, want %0d lat 6", i, $signed(val_imp), lat_imp, xs[i]);
      end
      n_tests++;
      if (cnt_wrap !== 1 || val_wrap !== 16'(xs[i]) || lat_wrap !== 5) begin
        n_fail++;
        $display("FAIL dry_wrap[%0d]: got %0d lat %0d, want %0d lat 5", i, $signed(val_wrap), lat_wrap, xs[i]);
      end
    end
  endtask

  task automatic test_mix_clamp();
    int exp_v [4] = '{8192, 0, 0, 8192};
    do_reset();
    mix = 5'd8;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mix = 5'd31;
      send((i == 0) ? 16'd16384 : 16'd0);
      n_tests++;
      if (val_imp !== 16'(exp_v[i])) begin
        n_fail++;
        $display("FAIL mix[%0d]: got %0d, want %0d", i, $signed(val_imp), exp_v[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    mix = 5'd16;
    for (int i = 0; i < 6; i++) begin
      send(16'd32767);
      n_tests++;
      if (cnt_sat !== 1 || val_sat !== ((i == 0) ? 16'd0 : 16'd32767)) begin
        n_fail++;
        $display("FAIL saturation[%0d]: got %0d, want %0d", i, $signed(val_sat), (i == 0) ? 0 : 32767);
      end
    end
  endtask

  task automatic test_wrap();
    int exp_v;
    do_reset();
    mix = 5'd16;
    for (int n = 0; n < 40; n++) begin
      send(16'(10 * n + 7));
      exp_v = (n < 15) ? 0 : ((10 * (n - 15) + 7) >> 1);
      n_tests++;
      if (cnt_wrap !== 1 || val_wrap !== 16'(exp_v)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got %0d (pulses %0d), want %0d", n, $signed(val_wrap), cnt_wrap, exp_v);
      end
    end
  endtask

  task automatic test_handshake();
    int          pulses = 0;
    logic [15:0] last = 'x;
    do_reset();
    mix = 5'd0;
    @(negedge clk_50m);
    signal_in = 16'd1234;
    ready_in  = 1'b1;
    @(negedge clk_50m);
    ready_in  = 1'b0;
    @(negedge clk_50m);
    n_tests++;
    if (imp_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL handshake_busy: got %b, want 1", imp_if.busy);
    end
    signal_in = 16'(-777);
    ready_in  = 1'b1;
    @(negedge clk_50m);
    ready_in  = 1'b0;
    for (int j = 0; j < 14; j++) begin
      if (imp_if.ready_out) begin pulses++; last = imp_if.signal_out; end
      @(negedge clk_50m);
    end
    n_tests++;
    if (pulses !== 1 || last !== 16'd1234) begin
      n_fail++;
      $display("FAIL handshake_drop: got %0d pulses value %0d, want 1 pulse value 1234", pulses, $signed(last));
    end
    send(16'd555);
    n_tests++;
    if (cnt_imp !== 1 || val_imp !== 16'd555 || lat_imp !== 6) begin
      n_fail++;
      $display("FAIL handshake_next: got %0d lat %0d, want 555 lat 6", $signed(val_imp), lat_imp);
    end
  endtask

  task automatic test_bypass();
    reverb_on = 1'b0;
    send(16'd321);
    n_tests++;
    if (cnt_imp !== 1 || val_imp !== 16'd321 || lat_imp !== 0) begin
      n_fail++;
      $display("FAIL bypass_a: got %0d lat %0d pulses %0d, want 321 lat 0 pulses 1", $signed(val_imp), lat_imp, cnt_imp);
    end
    send(16'(-5));
    n_tests++;
    if (cnt_wrap !== 1 || val_wrap !== 16'(-5) || lat_wrap !== 0) begin
      n_fail++;
      $display("FAIL bypass_b: got %0d lat %0d, want -5 lat 0", $signed(val_wrap), lat_wrap);
    end
    reverb_on = 1'b1;
  endtask

  task automatic test_abort_bypass();
    int pulses = 0;
    int exp_v [6] = '{0, 0, 0, 8192, 0, 4096};
    do_reset();
    mix = 5'd16;
    for (int i = 0; i < 16; i++) send(16'd4000);
    @(negedge clk_50m);
    signal_in = 16'd4000;
    ready_in  = 1'b1;
    @(negedge clk_50m);
    ready_in  = 1'b0;
    @(negedge clk_50m);
    reverb_on = 1'b0;
    @(negedge clk_50m);
    n_tests++;
    if (imp_if.busy !== 1'b0 || imp_if.ready_out !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_bypass_busy: got busy=%b rdy=%b, want 0 0", imp_if.busy, imp_if.ready_out);
    end
    reverb_on = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (imp_if.ready_out) pulses++;
      @(negedge clk_50m);
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_bypass_rdy: got %0d pulses, want 0", pulses);
    end
    for (int i = 0; i < 6; i++) begin
      send((i == 0) ? 16'd16384 : 16'd0);
      n_tests++;
      if (cnt_imp !== 1 || val_imp !== 16'(exp_v[i])) begin
        n_fail++;
        $display("FAIL abort_history[%0d]: got %0d, want %0d", i, $signed(val_imp), exp_v[i]);
      end
    end
  endtask

  task automatic test_abort_reset();
    int pulses = 0;
    mix = 5'd16;
    @(negedge clk_50m);
    signal_in = 16'd16384;
    ready_in  = 1'b1;
    @(negedge clk_50m);
    ready_in  = 1'b0;
    @(negedge clk_50m);
    rst_n = 1'b0;
    @(negedge clk_50m);
    n_tests++;
    if (imp_if.busy !== 1'b0 || imp_if.ready_out !== 1'b0 || imp_if.signal_out !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_reset: got busy=%b rdy=%b out=%0d, want 0 0 0",
               imp_if.busy, imp_if.ready_out, imp_if.signal_out);
    end
    rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (imp_if.ready_out) pulses++;
      @(negedge clk_50m);
    end
    n_tests++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL abort_reset_rdy: got %0d pulses, want 0", pulses);
    end
    send(16'd16384);
    n_tests++;
    if (cnt_imp !== 1 || val_imp !== 16'd0) begin
      n_fail++;
      $display("FAIL abort_reset_first: got %0d, want 0", $signed(val_imp));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    reverb_on = 1'b1;
    ready_in  = 1'b0;
    signal_in = 16'd0;
    mix       = 5'd16;
    test_reset();
    test_impulse();
    test_dry_path();
    test_mix_clamp();
    test_saturation();
    test_wrap();
    test_handshake();
    test_bypass();
    test_abort_bypass();
    test_abort_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
